// File: rtl/regfile_multiport_sb_if.sv
// Operand-fetch / writeback / reserve bus of the multiport register file.
// Decode and writeback drive through master; the register file sits on slave.
interface regfile_multiport_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int N_RD   = 2
);
  logic [N_RD*ADDR_W-1:0] rd_addr;
  logic                   rd_ld;
  logic                   rd_clr;
  logic [N_RD*DATA_W-1:0] rd_data;
  logic [N_RD-1:0]        rd_busy;
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   rsv_en;
  logic [ADDR_W-1:0]      rsv_addr;
  logic [2**ADDR_W-1:0]   busy_vec;

  modport master (
    output rd_addr, rd_ld, rd_clr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, rd_ld, rd_clr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_multiport_sb.sv
// Register file, N_RD registered read ports (1 cycle), one write port, busy scoreboard; no backpressure.
// Define RF_BYPASS_EN to forward same-cycle writeback data into the read ports.
module regfile_multiport_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_multiport_sb_if.slave  rf
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]      regs_q [DEPTH];
  logic [DEPTH-1:0]       busy_q;
  logic [DEPTH-1:0]       busy_d;
  logic [N_RD*DATA_W-1:0] rd_data_q;
  logic [N_RD*DATA_W-1:0] rd_data_d;
  logic [N_RD-1:0]        rd_busy_q;
  logic [N_RD-1:0]        rd_busy_d;
  logic [ADDR_W-1:0]      ra;
  logic [DATA_W-1:0]      rv;
  logic                   rb;
  logic                   wr_ok;

  assign wr_ok = rf.wr_en && !((ZERO_REG != 0) && (rf.wr_addr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[rf.wr_addr] <= rf.wr_data;
    end
  end

  // Reserve is applied after the writeback clear so a same-address pair ends busy.
  always_comb begin
    busy_d = busy_q;
    if (rf.wr_en) begin
      busy_d[rf.wr_addr] = 1'b0;
    end
    if (rf.rsv_en) begin
      busy_d[rf.rsv_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    ra        = '0;
    rv        = '0;
    rb        = 1'b0;
    if (rf.rd_clr) begin
      rd_data_d = '0;
      rd_busy_d = '0;
    end else if (rf.rd_ld) begin
      for (int p = 0; p < N_RD; p++) begin
        ra = rf.rd_addr[p*ADDR_W +: ADDR_W];
        rv = regs_q[ra];
        rb = busy_q[ra];
`ifdef RF_BYPASS_EN
        if (rf.wr_en && (ra == rf.wr_addr)) begin
          rv = rf.wr_data;
          rb = rf.rsv_en && (rf.rsv_addr == rf.wr_addr);
        end
`endif
        if ((ZERO_REG != 0) && (ra == '0)) begin
          rv = '0;
          rb = 1'b0;
        end
        rd_data_d[p*DATA_W +: DATA_W] = rv;
        rd_busy_d[p]                  = rb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rf.rd_data  = rd_data_q;
  assign rf.rd_busy  = rd_busy_q;
  assign rf.busy_vec = busy_q;
endmodule

// File: tb/tb_regfile_multiport_sb.sv
// Bench for regfile_multiport_sb: one instance with ZERO_REG=0 and one with ZERO_REG=1 on shared stimulus.
// Expected read results are queued when a cycle is driven and checked after its edge.
module tb_regfile_multiport_sb;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NR*AW-1:0] rd_addr  = '0;
  logic             rd_ld    = 1'b0;
  logic             rd_clr   = 1'b0;
  logic             wr_en    = 1'b0;
  logic [AW-1:0]    wr_addr  = '0;
  logic [DW-1:0]    wr_data  = '0;
  logic             rsv_en   = 1'b0;
  logic [AW-1:0]    rsv_addr = '0;

  regfile_multiport_sb_if #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR)) if0 ();
  regfile_multiport_sb_if #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR)) if1 ();

  assign if0.rd_addr = rd_addr;   assign if1.rd_addr = rd_addr;
  assign if0.rd_ld = rd_ld;       assign if1.rd_ld = rd_ld;
  assign if0.rd_clr = rd_clr;     assign if1.rd_clr = rd_clr;
  assign if0.wr_en = wr_en;       assign if1.wr_en = wr_en;
  assign if0.wr_addr = wr_addr;   assign if1.wr_addr = wr_addr;
  assign if0.wr_data = wr_data;   assign if1.wr_data = wr_data;
  assign if0.rsv_en = rsv_en;     assign if1.rsv_en = rsv_en;
  assign if0.rsv_addr = rsv_addr; assign if1.rsv_addr = rsv_addr;

  regfile_multiport_sb #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst(rst), .rf(if0.slave));
  regfile_multiport_sb #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_REG(1)) dut1 (
    .clk(clk), .rst(rst), .rf(if1.slave));

  typedef struct packed {
    logic [NR*DW-1:0] d;
    logic [NR-1:0]    b;
  } exp_t;

  exp_t        sb_q [2][$];
  logic [DW-1:0] m_reg  [2][16];
  logic [15:0]   m_busy [2];
  exp_t          m_out  [2];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic idle();
    rst = 1'b0; rd_ld = 1'b0; rd_clr = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
  endtask

  // One clock: queue expected read outputs, clock, update reference state, check both instances.
  task automatic cycle();
    exp_t e;
    exp_t got;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          b;
    for (int k = 0; k < 2; k++) begin
      e = m_out[k];
      if (rst || rd_clr) begin
        e = '0;
      end else if (rd_ld) begin
        for (int p = 0; p < NR; p++) begin
          a = rd_addr[p*AW +: AW];
          d = m_reg[k][a];
          b = m_busy[k][a];
`ifdef RF_BYPASS_EN
          if (wr_en && a == wr_addr) begin
            d = wr_data;
            b = rsv_en && (rsv_addr == wr_addr);
          end
`endif
          if (k == 1 && a == 0) begin
            d = '0;
            b = 1'b0;
          end
          e.d[p*DW +: DW] = d;
          e.b[p]          = b;
        end
      end
      sb_q[k].push_back(e);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) m_reg[k][i] = '0;
        m_busy[k] = '0;
      end else begin
        if (wr_en && !(k == 1 && wr_addr == 0)) m_reg[k][wr_addr] = wr_data;
        if (wr_en) m_busy[k][wr_addr] = 1'b0;
        if (rsv_en) m_busy[k][rsv_addr] = 1'b1;
        if (k == 1) m_busy[k][0] = 1'b0;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      if (sb_q[k].size() == 0) begin
        chk_eq("sb_underflow", 64'd0, 64'd1);
      end else begin
        e = sb_q[k].pop_front();
        m_out[k] = e;
        got.d = (k == 0) ? if0.rd_data : if1.rd_data;
        got.b = (k == 0) ? if0.rd_busy : if1.rd_busy;
        chk_eq(k == 0 ? "rd_data_z0" : "rd_data_z1", 64'(got.d), 64'(e.d));
        chk_eq(k == 0 ? "rd_busy_z0" : "rd_busy_z1", 64'(got.b), 64'(e.b));
        chk_eq(k == 0 ? "busy_vec_z0" : "busy_vec_z1",
               64'((k == 0) ? if0.busy_vec : if1.busy_vec), 64'(m_busy[k]));
      end
    end
    idle();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) m_reg[k][i] = '0;
      m_busy[k] = '0;
      m_out[k]  = '0;
    end
    @(negedge clk);

    // Reset while loading every address pair.
    for (int a = 0; a < 16; a += 2) begin
      rst = 1'b1; rd_ld = 1'b1; rd_addr = {4'(a + 1), 4'(a)};
      cycle();
    end
    chk_eq("reset_rd_data", 64'(if0.rd_data), 64'd0);
    chk_eq("reset_busy_vec", 64'(if0.busy_vec), 64'd0);

    // Write then dual-port read of the same register, then clear.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF; cycle();
    rd_ld = 1'b1; rd_addr = {4'd5, 4'd5}; cycle();
    chk_eq("wr5_port0", 64'(if0.rd_data[31:0]), 64'hDEADBEEF);
    chk_eq("wr5_port1", 64'(if0.rd_data[63:32]), 64'hDEADBEEF);
    rd_clr = 1'b1; rd_ld = 1'b1; cycle();
    chk_eq("rd_clr", 64'(if0.rd_data), 64'd0);

    // Reserve / read busy / writeback clears.
    rsv_en = 1'b1; rsv_addr = 4'd3; cycle();
    chk_eq("rsv3_busy", 64'(if0.busy_vec[3]), 64'd1);
    rd_ld = 1'b1; rd_addr = {4'd0, 4'd3}; cycle();
    chk_eq("rsv3_rd_busy", 64'(if0.rd_busy[0]), 64'd1);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'd7; cycle();
    chk_eq("wb3_busy", 64'(if0.busy_vec[3]), 64'd0);
    rd_ld = 1'b1; rd_addr = {4'd0, 4'd3}; cycle();
    chk_eq("wb3_data", 64'(if0.rd_data[31:0]), 64'd7);
    chk_eq("wb3_rd_busy", 64'(if0.rd_busy[0]), 64'd0);

    // Same-cycle write and reserve of r9.
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'd1; rsv_en = 1'b1; rsv_addr = 4'd9; cycle();
    chk_eq("coll9_busy", 64'(if0.busy_vec[9]), 64'd1);
    rd_ld = 1'b1; rd_addr = {4'd9, 4'd9}; cycle();
    chk_eq("coll9_data", 64'(if0.rd_data[63:32]), 64'd1);

    // Read in the same cycle as a write to the same register.
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'd2; cycle();
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'd10; rd_ld = 1'b1; rd_addr = {4'd5, 4'd4}; cycle();
`ifdef RF_BYPASS_EN
    chk_eq("byp4_data", 64'(if0.rd_data[31:0]), 64'd10);
`else
    chk_eq("byp4_data", 64'(if0.rd_data[31:0]), 64'd2);
`endif
    rd_ld = 1'b1; rd_addr = {4'd5, 4'd4}; cycle();
    chk_eq("byp4_next", 64'(if0.rd_data[31:0]), 64'd10);
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 32'd3; rsv_en = 1'b1; rsv_addr = 4'd6;
    rd_ld = 1'b1; rd_addr = {4'd6, 4'd6}; cycle();
    cycle();

    // Register zero handling, then reset during a reservation.
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'd55; rsv_en = 1'b1; rsv_addr = 4'd0; cycle();
    chk_eq("z1_r0_busy", 64'(if1.busy_vec[0]), 64'd0);
    rd_ld = 1'b1; rd_addr = {4'd0, 4'd0}; cycle();
    chk_eq("z1_r0_data", 64'(if1.rd_data[31:0]), 64'd0);
    chk_eq("z0_r0_data", 64'(if0.rd_data[31:0]), 64'd55);
    rsv_en = 1'b1; rsv_addr = 4'd12; cycle();
    rst = 1'b1; rsv_en = 1'b1; rsv_addr = 4'd12; cycle();
    chk_eq("rst_r12_busy", 64'(if1.busy_vec[12]), 64'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 39) == 0);
      rd_clr   = ($urandom_range(0, 7) == 0);
      rd_ld    = ($urandom_range(0, 1) == 1);
      rd_addr  = NR*AW'($urandom);
      wr_en    = ($urandom_range(0, 1) == 1);
      wr_addr  = AW'($urandom_range(0, 15));
      wr_data  = $urandom;
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rd_addr[AW-1:0] = wr_addr;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
